bpu_update_scheduler: RTL

BPU_UPDATE_SCHEDULER -- requirements
Module: bpu_update_scheduler

---
 rtl/bpu_update_scheduler_if.sv | 39 +++
 rtl/bpu_update_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bpu_update_scheduler_if.sv
// ============================================================================
// bpu_update_scheduler_if : ID/EX update requests and registered table-write bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface bpu_update_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int HASH_DEPTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  clr_req;
    logic                  flush;
    logic                  id_vld;
    logic                  id_rdy;
    logic [ADDR_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_data;
    logic                  ex_vld;
    logic                  ex_rdy;
    logic [ADDR_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_data;
    logic                  wr_en;
    logic [HASH_DEPTH-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [1:0]            wr_src;
    logic                  init_done;

    modport master (
        output clr_req, flush, id_vld, id_pc, id_data, ex_vld, ex_pc, ex_data,
        input  id_rdy, ex_rdy, wr_en, wr_idx, wr_data, wr_src, init_done
    );

    modport slave (
        input  clr_req, flush, id_vld, id_pc, id_data, ex_vld, ex_pc, ex_data,
        output id_rdy, ex_rdy, wr_en, wr_idx, wr_data, wr_src, init_done
    );
endinterface

`default_nettype wire

// File: rtl/bpu_update_scheduler.sv
// ============================================================================
// bpu_update_scheduler : clears the predictor table, then arbitrates ID installs
// against a FIFO of EX updates into one registered write port.  Rev 1.0
// ============================================================================
`default_nettype none

module bpu_update_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int HASH_DEPTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    bpu_update_scheduler_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0]            c_src_clr   = 2'b00;
    localparam logic [1:0]            c_src_id    = 2'b01;
    localparam logic [1:0]            c_src_ex    = 2'b10;
    localparam logic [PTR_W:0]        c_ptr_one   = (PTR_W+1)'(1);
    localparam logic [HASH_DEPTH-1:0] c_cnt_one   = HASH_DEPTH'(1);
    localparam logic [1:0]            c_starv_one = 2'd1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [HASH_DEPTH-1:0] r_clr_cnt;
    logic [1:0]            r_starv;
    logic [PTR_W:0]        r_wptr;
    logic [PTR_W:0]        r_rptr;
    logic [HASH_DEPTH-1:0] r_q_idx  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [FIFO_DEPTH];
    logic                  r_wr_en;
    logic [HASH_DEPTH-1:0] r_wr_idx;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [1:0]            r_wr_src;

    logic [HASH_DEPTH-1:0] w_id_idx;
    logic [HASH_DEPTH-1:0] w_ex_idx;
    logic                  w_run;
    logic                  w_hold;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_id_gnt;
    logic                  w_ex_gnt;
    logic                  w_enq;
    logic                  w_unused_pc_bits;

    assign w_id_idx = bus.id_pc[HASH_DEPTH+1:2] ^ bus.id_pc[2*HASH_DEPTH+1:HASH_DEPTH+2];
    assign w_ex_idx = bus.ex_pc[HASH_DEPTH+1:2] ^ bus.ex_pc[2*HASH_DEPTH+1:HASH_DEPTH+2];
    assign w_unused_pc_bits = ^{bus.id_pc[ADDR_WIDTH-1:2*HASH_DEPTH+2], bus.id_pc[1:0],
                                bus.ex_pc[ADDR_WIDTH-1:2*HASH_DEPTH+2], bus.ex_pc[1:0]};

    assign w_run   = (r_state == S_RUN);
    assign w_hold  = bus.flush | bus.clr_req;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

    // id_rdy deliberately ignores id_vld so the ID stage sees no combinational loop.
    assign bus.id_rdy    = w_run & (w_empty | (r_starv == 2'd3)) & ~w_hold;
    assign bus.ex_rdy    = w_run & ~w_full;
    assign bus.init_done = w_run;

    assign w_id_gnt = bus.id_vld & bus.id_rdy;
    assign w_ex_gnt = w_run & ~w_hold & ~w_empty & ~w_id_gnt;
    assign w_enq    = bus.ex_vld & bus.ex_rdy & ~w_hold;

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_idx  = r_wr_idx;
    assign bus.wr_data = r_wr_data;
    assign bus.wr_src  = r_wr_src;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_idx[r_wptr[PTR_W-1:0]]  <= w_ex_idx;
            r_q_data[r_wptr[PTR_W-1:0]] <= bus.ex_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_INIT;
            r_clr_cnt <= '0;
            r_starv   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
            r_wr_src  <= c_src_clr;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_starv <= '0;
                    if (bus.clr_req) begin
                        r_clr_cnt <= '0;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_idx  <= r_clr_cnt;
                        r_wr_data <= '0;
                        r_wr_src  <= c_src_clr;
                        r_clr_cnt <= r_clr_cnt + c_cnt_one;
                        if (&r_clr_cnt) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.clr_req) begin
                        r_state   <= S_INIT;
                        r_clr_cnt <= '0;
                        r_starv   <= '0;
                        r_wptr    <= '0;
                        r_rptr    <= '0;
                    end else if (bus.flush) begin
                        r_starv <= '0;
                        r_wptr  <= '0;
                        r_rptr  <= '0;
                    end else begin
                        if (w_enq) begin
                            r_wptr <= r_wptr + c_ptr_one;
                        end
                        if (w_id_gnt) begin
                            r_wr_en   <= 1'b1;
                            r_wr_idx  <= w_id_idx;
                            r_wr_data <= bus.id_data;
                            r_wr_src  <= c_src_id;
                            r_starv   <= '0;
                        end else if (w_ex_gnt) begin
                            r_wr_en   <= 1'b1;
                            r_wr_idx  <= r_q_idx[r_rptr[PTR_W-1:0]];
                            r_wr_data <= r_q_data[r_rptr[PTR_W-1:0]];
                            r_wr_src  <= c_src_ex;
                            r_rptr    <= r_rptr + c_ptr_one;
                            // Saturation is unnecessary: at 3 a waiting ID always wins.
                            r_starv   <= bus.id_vld ? (r_starv + c_starv_one) : 2'd0;
                        end else begin
                            r_starv <= '0;
                        end
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

endmodule

`default_nettype wire
